// File: rtl/fft_pkg.sv
// Shared constants and controller state encoding for the magnitude sequencer.
package fft_pkg;

  localparam int DEFAULT_SAMPLE_SIZE = 16;
  localparam int DEFAULT_BUFFER_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SQ_RE = 3'd1,
    ST_SQ_IM = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/magnitude_squarer.sv
// Combinational signed squarer; the result is always non-negative, so it is
// returned unsigned at full 2*SAMPLE_SIZE width (covers the most-negative input).
module magnitude_squarer
  import fft_pkg::*;
#(
  parameter int SAMPLE_SIZE = DEFAULT_SAMPLE_SIZE
) (
  input  logic signed [SAMPLE_SIZE-1:0]   sample,
  output logic        [2*SAMPLE_SIZE-1:0] square
);

  logic signed [2*SAMPLE_SIZE-1:0] sample_ext;
  logic signed [2*SAMPLE_SIZE-1:0] product;

  assign sample_ext = {{SAMPLE_SIZE{sample[SAMPLE_SIZE-1]}}, sample};
  assign product    = sample_ext * sample_ext;
  assign square     = product;

endmodule

// File: rtl/magnitude_sequencer.sv
// Streams |X[k]|^2 for each bin of a latched complex frame, reusing one squarer
// for the real and imaginary parts on consecutive cycles.
module magnitude_sequencer
  import fft_pkg::*;
#(
  parameter int SAMPLE_SIZE = DEFAULT_SAMPLE_SIZE,
  parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] frame_real,
  input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] frame_imag,
  output logic                               busy,
  output logic                               mag_valid,
  input  logic                               mag_ready,
  output logic [2*SAMPLE_SIZE:0]             mag_data,
  output logic [$clog2(BUFFER_SIZE)-1:0]     mag_index,
  output logic                               done
);

  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam int SQ_W  = 2*SAMPLE_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_SIZE-1);

  seq_state_e                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [SQ_W:0]                 acc_q, acc_d;
  logic signed [SAMPLE_SIZE-1:0] re_q [BUFFER_SIZE];
  logic signed [SAMPLE_SIZE-1:0] im_q [BUFFER_SIZE];
  logic [SAMPLE_SIZE-1:0]        bus_re [BUFFER_SIZE];
  logic [SAMPLE_SIZE-1:0]        bus_im [BUFFER_SIZE];
  logic signed [SAMPLE_SIZE-1:0] operand;
  logic [SQ_W-1:0]               square;
  logic                          accept;
  logic                          handshake;

  genvar gi;
  generate
    for (gi = 0; gi < BUFFER_SIZE; gi++) begin : g_unpack
      assign bus_re[gi] = frame_real[gi*SAMPLE_SIZE +: SAMPLE_SIZE];
      assign bus_im[gi] = frame_imag[gi*SAMPLE_SIZE +: SAMPLE_SIZE];
    end
  endgenerate

  assign accept    = (state_q == ST_IDLE) && start;
  assign handshake = (state_q == ST_EMIT) && mag_ready;

  // SQ_IM is the only cycle that needs the imaginary operand.
  assign operand = (state_q == ST_SQ_IM) ? im_q[idx_q] : re_q[idx_q];

  magnitude_squarer #(
    .SAMPLE_SIZE(SAMPLE_SIZE)
  ) u_squarer (
    .sample(operand),
    .square(square)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SQ_RE;
            idx_d   = '0;
          end
        end
        ST_SQ_RE: begin
          acc_d   = {1'b0, square};
          state_d = ST_SQ_IM;
        end
        ST_SQ_IM: begin
          acc_d   = acc_q + {1'b0, square};
          state_d = ST_EMIT;
        end
        ST_EMIT: begin
          if (handshake) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_SQ_RE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Frame is captured only on acceptance; bus activity afterwards is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BUFFER_SIZE; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < BUFFER_SIZE; k++) begin
        re_q[k] <= bus_re[k];
        im_q[k] <= bus_im[k];
      end
    end
  end

  assign busy      = (state_q == ST_SQ_RE) || (state_q == ST_SQ_IM) || (state_q == ST_EMIT);
  assign mag_valid = (state_q == ST_EMIT);
  assign done      = (state_q == ST_DONE);
  assign mag_data  = acc_q;
  assign mag_index = idx_q;

endmodule

// File: tb/tb_magnitude_sequencer.sv
// Directed scoreboard bench for magnitude_sequencer: stimulus pushes expected
// bins into a queue, a negedge monitor pops and compares on every handshake.
module tb_magnitude_sequencer;

  localparam int SS = 16;
  localparam int BS = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [BS*SS-1:0]   frame_real = '0;
  logic [BS*SS-1:0]   frame_imag = '0;
  logic               busy;
  logic               mag_valid;
  logic               mag_ready = 1'b1;
  logic [2*SS:0]      mag_data;
  logic [2:0]         mag_index;
  logic               done;

  magnitude_sequencer #(.SAMPLE_SIZE(SS), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_real(frame_real), .frame_imag(frame_imag),
    .busy(busy), .mag_valid(mag_valid), .mag_ready(mag_ready),
    .mag_data(mag_data), .mag_index(mag_index), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; longint data; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int tbl_re [2][8] = '{'{3, 0, -1, 100, -32768, 32767, -5, 7},
                        '{1, 2, -3, 10, 0, 255, -32768, 6}};
  int tbl_im [2][8] = '{'{4, 0, 1, -200, -32768, 0, 12, -24},
                        '{1, 2, -3, 0, -10, 255, 32767, 8}};
  longint tbl_mag [2][8] = '{'{25, 0, 2, 50000, 64'd2147483648, 1073676289, 169, 625},
                             '{2, 8, 18, 100, 100, 130050, 64'd2147418113, 100}};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mag_valid && mag_ready && !abort) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output_index", longint'(mag_index), -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("bin_index", longint'(mag_index), e.idx);
        check("bin_data", longint'(mag_data), e.data);
        $display("bin %0d: mag_data=%0d (expected %0d)", mag_index, mag_data, e.data);
      end
    end
  end

  task automatic load_frame(input int which);
    for (int k = 0; k < BS; k++) begin
      frame_real[k*SS +: SS] = SS'(tbl_re[which][k]);
      frame_imag[k*SS +: SS] = SS'(tbl_im[which][k]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_valid"}, longint'(mag_valid), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_data"}, longint'(mag_data), 0);
    check({tag, "_index"}, longint'(mag_index), 0);
  endtask

  // abort_at / rst_at: cycle after acceptance at which to cancel (0 = never);
  // stall_bin: bin held for 5 cycles of mag_ready low (-1 = none);
  // junk_at: cycle at which to retrigger start and scramble the buses (0 = never).
  task automatic run_frame(input int which, input int abort_at, input int rst_at,
                           input int stall_bin, input int junk_at);
    int cyc = 0;
    int stalls = 0;
    int first_v = -1;
    int done_c = -1;
    int n_exp;
    bit cancelled = 0;
    n_exp = (abort_at > 0) ? (abort_at - 2) / 3 : (rst_at > 0) ? (rst_at - 3) / 3 : BS;
    load_frame(which);
    for (int k = 0; k < n_exp; k++) sb_q.push_back('{k, tbl_mag[which][k]});
    @(posedge clk); #1;
    start = 1'b1;
    mag_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", longint'(busy), 1);
    while (cyc < 200) begin
      cyc++;
      if (mag_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_c = cyc;
        break;
      end
      if (junk_at == cyc) begin
        frame_real = {BS{16'h7777}};
        frame_imag = {BS{16'h1234}};
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall_bin >= 0 && mag_valid && (int'(mag_index) == stall_bin) && stalls < 5) begin
        mag_ready = 1'b0;
        check("stall_valid", longint'(mag_valid), 1);
        check("stall_index", longint'(mag_index), stall_bin);
        check("stall_data", longint'(mag_data), tbl_mag[which][stall_bin]);
        stalls++;
      end else begin
        mag_ready = 1'b1;
      end
      if (abort_at == cyc) begin
        check("abort_bin_index", longint'(mag_index), 4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_valid", longint'(mag_valid), 0);
        for (int i = 0; i < 5; i++) begin
          check("abort_no_done", longint'(done), 0);
          @(posedge clk); #1;
        end
        cancelled = 1;
        break;
      end
      if (rst_at == cyc) begin
        check("pre_reset_valid", longint'(mag_valid), 1);
        check("pre_reset_index", longint'(mag_index), 6);
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_done", longint'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_idle", longint'(busy), 0);
        cancelled = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!cancelled) begin
      check("first_valid_cycle", first_v, 3);
      check("done_cycle", done_c, 25 + stalls);
      if (stall_bin >= 0) check("stall_cycles", stalls, 5);
      start = (junk_at > 0);
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", longint'(done), 0);
      check("idle_after_done", longint'(busy), 0);
    end
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
    $display("frame %0d finished: done_cycle=%0d stalls=%0d", which, done_c, stalls);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;
    run_frame(0, 0, 0, -1, 0);
    run_frame(1, 0, 0, 2, 4);
    run_frame(0, 14, 0, -1, 0);
    run_frame(1, 0, 0, -1, 0);
    run_frame(0, 0, 21, -1, 0);
    run_frame(1, 0, 0, -1, 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
